// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO with registered read data, level flags and sticky error flags
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   rd,
  input  logic                   err_clr,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_ok, rd_ok;
  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);
  assign wr_ok = wr && !full && !flush;
  assign rd_ok = rd && !empty && !flush;
  // storage is deliberately not reset; it is only visible through accepted reads
  always_ff @(posedge clock)
    if (wr_ok) mem[wp] <= data_in;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !err_clr) || (wr && full && !flush);
      underflow <= (underflow && !err_clr) || (rd && empty && !flush);
      rd_valid  <= rd_ok;
      if (flush) begin
        wp    <= '0;
        rp    <= '0;
        count <= '0;
      end else begin
        if (wr_ok) wp <= wp + 1'b1;
        if (rd_ok) begin
          rp       <= rp + 1'b1;
          data_out <= mem[rp];
        end
        count <= count + CW'(wr_ok) - CW'(rd_ok);
      end
    end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed checks of param_fifo with default parameters
module tb_param_fifo;
  logic       clock = 1'b0;
  logic       rst_n, flush, wr, rd, err_clr;
  logic [7:0] data_in, data_out;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int checks = 0;
  int errors = 0;

  param_fifo dut (
    .clock(clock), .rst_n(rst_n), .flush(flush), .wr(wr), .data_in(data_in),
    .rd(rd), .err_clr(err_clr), .data_out(data_out), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = 8'h00;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    tick; tick;
    rst_n = 1'b1;

    // fill 0x01..0x10 and watch the level flags
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; data_in = 8'(i);
      tick;
      chk("fill_count", count, i);
      chk("fill_af", almost_full, i >= 14);
      chk("fill_ae", almost_empty, i <= 2);
      chk("fill_full", full, i == 16);
    end
    wr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      rd = 1'b1;
      tick;
      chk("drain_rdv", rd_valid, 1);
      chk("drain_data", data_out, i);
      chk("drain_count", count, 16 - i);
    end
    rd = 1'b0;
    tick;
    chk("drain_rdv_low", rd_valid, 0);
    chk("drain_empty", empty, 1);

    // overflow behaviour
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; data_in = 8'(8'h20 + i);
      tick;
    end
    data_in = 8'hAA;
    tick;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    err_clr = 1'b1;
    tick;
    chk("ovf_clr_and_err", overflow, 1);
    wr = 1'b0;
    tick;
    chk("ovf_clr", overflow, 0);
    err_clr = 1'b0;
    rd = 1'b1; wr = 1'b1; data_in = 8'hBB;
    tick;
    chk("full_rw_count", count, 15);
    chk("full_rw_data", data_out, 8'h20);
    chk("full_rw_rdv", rd_valid, 1);
    chk("full_rw_ovf", overflow, 1);
    wr = 1'b0; rd = 1'b0; err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("full_rw_ovf_clr", overflow, 0);
    for (int i = 1; i < 16; i++) begin
      rd = 1'b1;
      tick;
      chk("ovf_drain_data", data_out, 8'h20 + i);
    end
    rd = 1'b0;
    tick;
    chk("ovf_drain_empty", empty, 1);

    // steady state at count 5 with wrapping pointers
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; data_in = 8'(8'h40 + i);
      tick;
    end
    rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'(8'h45 + i);
      tick;
      chk("steady_count", count, 5);
      chk("steady_data", data_out, 8'h40 + i);
      chk("steady_rdv", rd_valid, 1);
    end
    wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("steady_tail", data_out, 8'h54 + i);
    end
    rd = 1'b0;
    tick;
    chk("steady_empty", empty, 1);

    // read+write on empty
    rd = 1'b1; wr = 1'b1; data_in = 8'h3C;
    tick;
    chk("udf_set", underflow, 1);
    chk("udf_rdv", rd_valid, 0);
    chk("udf_count", count, 1);
    chk("udf_hold", data_out, 8'h58);
    wr = 1'b0;
    tick;
    chk("udf_next_data", data_out, 8'h3C);
    chk("udf_next_rdv", rd_valid, 1);
    rd = 1'b0; err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("udf_clr", underflow, 0);

    // flush overrides a concurrent write
    for (int i = 0; i < 7; i++) begin
      wr = 1'b1; data_in = 8'(8'h60 + i);
      tick;
    end
    chk("pre_flush_count", count, 7);
    flush = 1'b1; data_in = 8'h77;
    tick;
    flush = 1'b0; wr = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_dout", data_out, 8'h3C);
    rd = 1'b1;
    tick;
    rd = 1'b0;
    chk("flush_rd_udf", underflow, 1);
    chk("flush_rd_rdv", rd_valid, 0);
    chk("flush_rd_hold", data_out, 8'h3C);

    // async reset mid-operation, underflow still set from above
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1; data_in = 8'(8'h80 + i);
      tick;
    end
    wr = 1'b0;
    rd = 1'b1;
    tick;
    rd = 1'b0;
    chk("pre_rst_count", count, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ae", almost_empty, 1);
    chk("arst_dout", data_out, 0);
    chk("arst_rdv", rd_valid, 0);
    chk("arst_udf", underflow, 0);
    #1 rst_n = 1'b1;
    wr = 1'b1; data_in = 8'h55;
    tick;
    wr = 1'b0;
    chk("post_rst_count", count, 1);
    rd = 1'b1;
    tick;
    rd = 1'b0;
    chk("post_rst_data", data_out, 8'h55);
    chk("post_rst_rdv", rd_valid, 1);
    chk("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, width in bits of each stored word.
REQ-002 SHALL provide parameter DEPTH, default 16, number of entries; legal values are powers of two, 2 to 1024.
REQ-003 SHALL provide parameter AF_LEVEL, default 14, occupancy at or above which almost_full asserts; legal range 1 to DEPTH.
REQ-004 SHALL provide parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts; legal range 0 to DEPTH-1.
REQ-005 SHALL provide port clock, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL provide port flush, input, 1, synchronous clear of contents.
REQ-008 SHALL provide port wr, input, 1, write request.
REQ-009 SHALL provide port data_in, input, DATA_WIDTH, write data.
REQ-010 SHALL provide port rd, input, 1, read request.
REQ-011 SHALL provide port data_out, output, DATA_WIDTH, registered read data.
REQ-012 SHALL provide port rd_valid, output, 1, data_out updated this cycle.
REQ-013 SHALL provide port count, output, log2(DEPTH)+1, current occupancy.
REQ-014 SHALL provide ports full, empty, almost_full, almost_empty, each output, 1.
REQ-015 SHALL provide ports overflow, underflow, each output, 1, sticky error flags.
REQ-016 SHALL provide port err_clr, input, 1, synchronous clear of overflow and underflow.

Function
REQ-017 A write SHALL be accepted when wr=1 and full=0; data_in is stored at the write pointer, and the pointer advances.
REQ-018 A read SHALL be accepted when rd=1 and empty=0; the oldest entry is registered to data_out, the read pointer advances, and rd_valid=1 in the next cycle.
REQ-019 Read latency SHALL be one clock: an entry read at edge N is visible on data_out after edge N, with rd_valid high for exactly that cycle.
REQ-020 Simultaneous accepted read and write SHALL both occur in the same cycle, with count unchanged.
REQ-021 When full, rd=1 and wr=1 together SHALL accept only the read; the write is dropped and overflow sets.
REQ-022 When empty, rd=1 and wr=1 together SHALL accept only the write; the read is rejected, underflow sets, and data_out holds.
REQ-023 wr=1 while full SHALL set overflow and leave memory, pointers and count unchanged.
REQ-024 rd=1 while empty SHALL set underflow and leave data_out unchanged, with rd_valid=0.
REQ-025 overflow and underflow SHALL stay set until err_clr=1 or reset; if err_clr and a new error occur in the same cycle, the flag stays set.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-027 count SHALL range 0 to DEPTH; full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL); all flags are combinational from registered count.
REQ-028 flush=1 SHALL, at the next edge, zero both pointers and count and clear rd_valid, overriding wr and rd in that cycle; data_out and the error flags hold.
REQ-029 Data SHALL be returned in strict first-in first-out order for any interleaving of reads and writes.
REQ-030 Memory contents SHALL not be reset and SHALL not be observable except through accepted reads.

Reset
REQ-031 While rst_n=0, the block SHALL immediately and asynchronously force pointers=0, count=0, data_out=0, rd_valid=0, overflow=0 and underflow=0, giving empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-032 Reset assertion mid-operation SHALL discard all stored entries; the first edge after rst_n deasserts SHALL accept normal wr/rd.

Verification
REQ-033 Reset, then write 0x01..0x10 (16 writes) -> count=16, full=1, almost_full from count 14; then 16 reads -> data_out 0x01..0x10 in order, each one cycle after its rd, ending with empty=1.
REQ-034 Fill to 16, then drive wr=1 with data 0xAA -> overflow=1, count stays 16, 0xAA is never read; then err_clr=1 -> overflow=0.
REQ-035 Hold count=5 with rd=1 and wr=1 for 20 cycles -> count stays 5, pointers wrap, and the output stream matches the input stream delayed by 5 entries.
REQ-036 On an empty FIFO, drive rd=1 and wr=1 with 0x3C -> underflow=1, rd_valid=0, count=1; the next read returns 0x3C.
REQ-037 Write 7 entries, then flush=1 together with wr=1 -> count=0, empty=1, and the write is ignored.
REQ-038 Write 9 entries, then pulse rst_n low between clock edges -> outputs reach reset values before the next edge; a subsequent write/read of 0x55 returns 0x55.
